// File: rtl/dmem_arbiter_if.sv
// ============================================================================
// dmem_arbiter_if : request, response and memory-side signals of dmem_arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

interface dmem_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) ();
    logic              core_req;
    logic              core_we;
    logic [ADDR_W-1:0] core_addr;
    logic [DATA_W-1:0] core_wdata;
    logic              core_gnt;
    logic              core_stall;
    logic              core_rvalid;

    logic              ext_req;
    logic              ext_we;
    logic [ADDR_W-1:0] ext_addr;
    logic [DATA_W-1:0] ext_wdata;
    logic [4:0]        ext_len;
    logic              ext_gnt;
    logic              ext_rvalid;

    logic [DATA_W-1:0] rdata;

    logic              mem_rd;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_add;
    logic [DATA_W-1:0] mem_in;
    logic [DATA_W-1:0] mem_out;

    // Arbiter side
    modport slave (
        input  core_req, core_we, core_addr, core_wdata,
        input  ext_req, ext_we, ext_addr, ext_wdata, ext_len,
        input  mem_out,
        output core_gnt, core_stall, core_rvalid,
        output ext_gnt, ext_rvalid, rdata,
        output mem_rd, mem_wr, mem_add, mem_in
    );

    // Requesters and memory side
    modport master (
        output core_req, core_we, core_addr, core_wdata,
        output ext_req, ext_we, ext_addr, ext_wdata, ext_len,
        output mem_out,
        input  core_gnt, core_stall, core_rvalid,
        input  ext_gnt, ext_rvalid, rdata,
        input  mem_rd, mem_wr, mem_add, mem_in
    );
endinterface

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
// dmem_arbiter : shares one data memory between the core MEM stage and an
//                ext loader/debug port, with ext bursts and starvation guard
// Revision: 1.0
// ============================================================================
`default_nettype none

module dmem_arbiter #(
    parameter int ADDR_W   = 64,
    parameter int DATA_W   = 64,
    parameter int MAX_WAIT = 4
) (
    input  wire logic      clk,
    input  wire logic      rst,
    dmem_arbiter_if.slave  bus
);
    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

    typedef enum logic [0:0] {
        ARB       = 1'b0,
        EXT_BURST = 1'b1
    } state_t;

    state_t            state, state_nxt;
    logic [3:0]        wait_cnt, wait_cnt_nxt;
    logic [3:0]        beats_left, beats_left_nxt;
    logic [4:0]        len_eff;
    logic              ext_pri;
    logic              core_gnt, ext_gnt;
    logic              rd_xfer;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              core_rv, ext_rv;
    logic [DATA_W-1:0] rdata_q;

    always_comb begin
        state_nxt      = state;
        wait_cnt_nxt   = wait_cnt;
        beats_left_nxt = beats_left;
        core_gnt       = 1'b0;
        ext_gnt        = 1'b0;
        sel_addr       = '0;
        sel_wdata      = '0;

        len_eff = (bus.ext_len > 5'd16) ? 5'd16 : bus.ext_len;
        // Ext wins while a burst is open or once it has been refused long enough
        ext_pri = (state == EXT_BURST) || (wait_cnt >= WAIT_LIMIT);

        if (!rst) begin
            if (ext_pri) begin
                ext_gnt  = bus.ext_req;
                core_gnt = bus.core_req & ~bus.ext_req;
            end else begin
                core_gnt = bus.core_req;
                ext_gnt  = bus.ext_req & ~bus.core_req;
            end
        end

        if (ext_gnt) begin
            sel_addr  = bus.ext_addr;
            sel_wdata = bus.ext_wdata;
        end else if (core_gnt) begin
            sel_addr  = bus.core_addr;
            sel_wdata = bus.core_wdata;
        end

        if (!bus.ext_req || ext_gnt) begin
            wait_cnt_nxt = 4'd0;
        end else if (state == ARB && wait_cnt < WAIT_LIMIT) begin
            wait_cnt_nxt = wait_cnt + 4'd1;
        end

        case (state)
            ARB: begin
                if (ext_gnt && len_eff >= 5'd2) begin
                    state_nxt      = EXT_BURST;
                    beats_left_nxt = 4'(len_eff - 5'd1);
                end
            end
            EXT_BURST: begin
                if (ext_gnt) begin
                    if (beats_left == 4'd1) begin
                        state_nxt      = ARB;
                        beats_left_nxt = 4'd0;
                    end else begin
                        beats_left_nxt = beats_left - 4'd1;
                    end
                end
            end
            default: begin
                state_nxt      = ARB;
                beats_left_nxt = 4'd0;
            end
        endcase
    end

    assign rd_xfer = (core_gnt & ~bus.core_we) | (ext_gnt & ~bus.ext_we);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ARB;
            wait_cnt   <= 4'd0;
            beats_left <= 4'd0;
            core_rv    <= 1'b0;
            ext_rv     <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state      <= state_nxt;
            wait_cnt   <= wait_cnt_nxt;
            beats_left <= beats_left_nxt;
            core_rv    <= core_gnt & ~bus.core_we;
            ext_rv     <= ext_gnt & ~bus.ext_we;
            if (rd_xfer) begin
                rdata_q <= bus.mem_out;
            end
        end
    end

    assign bus.core_gnt    = core_gnt;
    assign bus.ext_gnt     = ext_gnt;
    assign bus.core_stall  = bus.core_req & ~core_gnt;
    assign bus.core_rvalid = core_rv;
    assign bus.ext_rvalid  = ext_rv;
    assign bus.rdata       = rdata_q;
    assign bus.mem_rd      = rd_xfer;
    assign bus.mem_wr      = (core_gnt & bus.core_we) | (ext_gnt & bus.ext_we);
    assign bus.mem_add     = sel_addr;
    assign bus.mem_in      = sel_wdata;
endmodule

`default_nettype wire
